// File: rtl/ks_pipe_adder.sv
// rtl/ks_pipe_adder.sv - pipelined Kogge-Stone adder/subtractor with valid/ready flow control
module ks_pipe_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int LEVELS = (WIDTH <= 1) ? 0 : $clog2(WIDTH);
    localparam int LAT    = LEVELS + 1;

    // Whole pipeline moves together; it only stops when a result is waiting unread.
    logic             advance;
    logic [WIDTH-1:0] bx;
    logic [WIDTH-1:0] g_in;
    logic [WIDTH-1:0] p_in;
    logic             c0_in;

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;
    assign bx       = b ^ {WIDTH{sub}};
    assign c0_in    = sub | cin;
    assign g_in     = a & bx;
    assign p_in     = a ^ bx;

    // Values about to be captured by the output register stage.
    logic [WIDTH-1:0] f_sum;
    logic             f_cout;
    logic             f_ovf;
    logic             f_valid;

    generate
        if (LEVELS == 0) begin : g_single
            // One-bit adder: no prefix tree, the output stage is the only stage.
            assign f_sum   = p_in ^ c0_in;
            assign f_cout  = g_in[0] | (p_in[0] & c0_in);
            assign f_ovf   = f_cout ^ c0_in;
            assign f_valid = in_valid;
        end else begin : g_ks
            // sg/sp: group generate/propagate after each level; sb: bitwise propagate
            // kept for the final sum; sc: carry-in; sv: slot valid.
            logic [LEVELS-1:0][WIDTH-1:0] sg;
            logic [LEVELS-1:0][WIDTH-1:0] sp;
            logic [LEVELS-1:0][WIDTH-1:0] sb;
            logic [LEVELS-1:0]            sc;
            logic [LEVELS-1:0]            sv;
            logic [LEVELS:1][WIDTH-1:0]   lg;
            logic [LEVELS:1][WIDTH-1:0]   lp;
            logic [WIDTH-1:0]             g_fold;
            logic [WIDTH-1:0]             carries;

            // Fold the carry-in into bit 0 so group generates become true carries.
            always_comb begin
                g_fold    = g_in;
                g_fold[0] = g_in[0] | (p_in[0] & c0_in);
            end

            for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
                localparam int SPAN = 1 << (k - 1);
                for (genvar i = 0; i < WIDTH; i++) begin : g_bit
                    if (i >= SPAN) begin : g_op
                        assign lg[k][i] = sg[k-1][i] | (sp[k-1][i] & sg[k-1][i-SPAN]);
                        assign lp[k][i] = sp[k-1][i] & sp[k-1][i-SPAN];
                    end else begin : g_pass
                        assign lg[k][i] = sg[k-1][i];
                        assign lp[k][i] = sp[k-1][i];
                    end
                end
            end

            // Stage 0 captures g/p/c0, stages 1..LEVELS-1 each hold one prefix level.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    sv <= '0;
                    sg <= '0;
                    sp <= '0;
                    sb <= '0;
                    sc <= '0;
                end else if (advance) begin
                    sv[0] <= in_valid;
                    sg[0] <= g_fold;
                    sp[0] <= p_in;
                    sb[0] <= p_in;
                    sc[0] <= c0_in;
                    for (int s = 1; s < LEVELS; s++) begin
                        sv[s] <= sv[s-1];
                        sg[s] <= lg[s];
                        sp[s] <= lp[s];
                        sb[s] <= sb[s-1];
                        sc[s] <= sc[s-1];
                    end
                end
            end

            // The last prefix level feeds the output registers directly.
            assign carries = {lg[LEVELS][WIDTH-2:0], sc[LEVELS-1]};
            assign f_sum   = sb[LEVELS-1] ^ carries;
            assign f_cout  = lg[LEVELS][WIDTH-1];
            assign f_ovf   = f_cout ^ carries[WIDTH-1];
            assign f_valid = sv[LEVELS-1];
        end
    endgenerate

    // Output stage: results leave straight from registers and hold during a stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
        end else if (advance) begin
            out_valid <= f_valid;
            sum       <= f_sum;
            cout      <= f_cout;
            ovf       <= f_ovf;
        end
    end

endmodule

// File: tb/tb_ks_pipe_adder.sv
// tb/tb_ks_pipe_adder.sv - self-checking bench for ks_pipe_adder
module tb_ks_pipe_adder;

    typedef struct {
        logic [65:0] r;
        int          c;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Behavioural reference: returns {ovf, cout, sum}.
    function automatic logic [65:0] ref_add(input int w, input logic [63:0] av, input logic [63:0] bv,
                                            input logic ci, input logic sb);
        logic [64:0] m, m2, bxv, full, low;
        logic        c0, cmsb;
        m    = (65'd1 << w) - 65'd1;
        m2   = (65'd1 << (w - 1)) - 65'd1;
        bxv  = sb ? (~{1'b0, bv}) & m : {1'b0, bv} & m;
        c0   = sb ? 1'b1 : ci;
        full = ({1'b0, av} & m) + bxv + {64'd0, c0};
        low  = ({1'b0, av} & m2) + (bxv & m2) + {64'd0, c0};
        cmsb = low[w-1];
        return {full[w] ^ cmsb, full[w], full[63:0] & m[63:0]};
    endfunction

    // ---------------- WIDTH=8 instance ----------------
    logic       in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
    logic [7:0] a, b, sum;

    ks_pipe_adder #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf)
    );

    exp_t        q8[$];
    int          n_out = 0;
    int          first_out = 0;
    int          last_out = 0;
    logic        lat_chk = 1'b1;
    int          st_from = -1;
    int          st_to = -1;
    logic        stall_prev = 1'b0;
    logic [10:0] snap;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) check("w8_freeze", {out_valid, ovf, cout, sum}, snap);
            stall_prev = out_valid && !out_ready;
            snap = {out_valid, ovf, cout, sum};
            if (out_valid && !out_ready) check("w8_stall_rdy", in_ready, 0);
            if (out_valid && out_ready) begin
                if (q8.size() == 0) begin
                    check("w8_extra", 1, 0);
                end else begin
                    e = q8.pop_front();
                    check("w8_res", {ovf, cout, sum}, {e.r[65:64], e.r[7:0]});
                    if (lat_chk) check("w8_lat", cyc - e.c, 4);
                end
                if (n_out == 0) first_out = cyc;
                last_out = cyc;
                n_out++;
            end
        end
    end

    task automatic send8(input logic [7:0] av, input logic [7:0] bv, input logic ci, input logic sb);
        exp_t e;
        int   tries = 0;
        logic acc = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b1; a = av; b = bv; cin = ci; sub = sb;
        while (!acc && tries < 50) begin
            out_ready = !(cyc >= st_from && cyc < st_to);
            @(negedge clk);
            if (in_ready) begin
                e.r = ref_add(8, {56'd0, av}, {56'd0, bv}, ci, sb);
                e.c = cyc;
                q8.push_back(e);
                acc = 1'b1;
            end else begin
                tries++;
                @(posedge clk);
                #1;
            end
        end
        if (!acc) check("w8_accept_timeout", 0, 1);
    endtask

    task automatic drain8();
        int t = 0;
        while (q8.size() != 0 && t < 40) begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            out_ready = 1'b1;
            t++;
        end
        check("w8_drain", q8.size(), 0);
    endtask

    // ---------------- width sweep instances ----------------
    int          sw_w[4]   = '{1, 5, 16, 64};
    int          sw_lat[4] = '{1, 4, 5, 7};
    logic        s_in_valid;
    logic        s_out_ready;
    logic [3:0]  s_in_ready, s_out_valid, s_cin, s_sub, s_cout, s_ovf;
    logic [63:0] s_a[4];
    logic [63:0] s_b[4];
    logic        s1_sum;
    logic [4:0]  s5_sum;
    logic [15:0] s16_sum;
    logic [63:0] s64_sum;
    exp_t        sq[4][$];

    ks_pipe_adder #(.WIDTH(1)) dut_w1 (
        .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready[0]),
        .a(s_a[0][0:0]), .b(s_b[0][0:0]), .cin(s_cin[0]), .sub(s_sub[0]),
        .out_valid(s_out_valid[0]), .out_ready(s_out_ready),
        .sum(s1_sum), .cout(s_cout[0]), .ovf(s_ovf[0])
    );
    ks_pipe_adder #(.WIDTH(5)) dut_w5 (
        .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready[1]),
        .a(s_a[1][4:0]), .b(s_b[1][4:0]), .cin(s_cin[1]), .sub(s_sub[1]),
        .out_valid(s_out_valid[1]), .out_ready(s_out_ready),
        .sum(s5_sum), .cout(s_cout[1]), .ovf(s_ovf[1])
    );
    ks_pipe_adder #(.WIDTH(16)) dut_w16 (
        .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready[2]),
        .a(s_a[2][15:0]), .b(s_b[2][15:0]), .cin(s_cin[2]), .sub(s_sub[2]),
        .out_valid(s_out_valid[2]), .out_ready(s_out_ready),
        .sum(s16_sum), .cout(s_cout[2]), .ovf(s_ovf[2])
    );
    ks_pipe_adder #(.WIDTH(64)) dut_w64 (
        .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready[3]),
        .a(s_a[3]), .b(s_b[3]), .cin(s_cin[3]), .sub(s_sub[3]),
        .out_valid(s_out_valid[3]), .out_ready(s_out_ready),
        .sum(s64_sum), .cout(s_cout[3]), .ovf(s_ovf[3])
    );

    always @(negedge clk) begin
        exp_t        e;
        logic [63:0] gs;
        if (!rst) begin
            for (int w = 0; w < 4; w++) begin
                if (s_out_valid[w]) begin
                    case (w)
                        0:       gs = {63'd0, s1_sum};
                        1:       gs = {59'd0, s5_sum};
                        2:       gs = {48'd0, s16_sum};
                        default: gs = s64_sum;
                    endcase
                    if (sq[w].size() == 0) begin
                        check($sformatf("sw_extra_w%0d", sw_w[w]), 1, 0);
                    end else begin
                        e = sq[w].pop_front();
                        check($sformatf("sw_res_w%0d", sw_w[w]), {s_ovf[w], s_cout[w], gs}, e.r);
                        check($sformatf("sw_lat_w%0d", sw_w[w]), cyc - e.c, sw_lat[w]);
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1;
        in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
        s_in_valid = 1'b0; s_out_ready = 1'b1; s_cin = '0; s_sub = '0;
        for (int w = 0; w < 4; w++) begin
            s_a[w] = '0;
            s_b[w] = '0;
        end
        #2;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_outputs", {sum, cout, ovf}, 0);
        #10 rst = 1'b0;

        // Directed vectors, hand-computed {ovf,cout,sum} also compared explicitly.
        check("hand_ff_01", ref_add(8, 64'hFF, 64'h01, 1'b0, 1'b0), {1'b0, 1'b1, 64'h00});
        send8(8'hFF, 8'h01, 1'b0, 1'b0);
        send8(8'h05, 8'h07, 1'b1, 1'b1);
        send8(8'h7F, 8'h01, 1'b0, 1'b0);
        send8(8'h80, 8'h01, 1'b0, 1'b1);
        send8(8'h10, 8'h20, 1'b1, 1'b0);
        send8(8'h00, 8'h00, 1'b0, 1'b1);
        drain8();
        check("hand_05_07", ref_add(8, 64'h05, 64'h07, 1'b1, 1'b1), {1'b0, 1'b0, 64'hFE});
        check("hand_7f_01", ref_add(8, 64'h7F, 64'h01, 1'b0, 1'b0), {1'b1, 1'b0, 64'h80});
        check("hand_80_01", ref_add(8, 64'h80, 64'h01, 1'b0, 1'b1), {1'b1, 1'b1, 64'h7F});
        check("hand_10_20", ref_add(8, 64'h10, 64'h20, 1'b1, 1'b0), {1'b0, 1'b0, 64'h31});
        check("hand_00_00", ref_add(8, 64'h00, 64'h00, 1'b0, 1'b1), {1'b0, 1'b1, 64'h00});

        // Back-to-back stream of 20 vectors.
        n_out = 0;
        for (int i = 0; i < 20; i++)
            send8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        drain8();
        check("stream_count", n_out, 20);
        check("stream_consecutive", last_out - first_out, 19);

        // Stream with a three-cycle output stall in the middle.
        n_out = 0;
        lat_chk = 1'b0;
        st_from = cyc + 7;
        st_to = st_from + 3;
        for (int i = 0; i < 10; i++)
            send8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        drain8();
        check("stall_count", n_out, 10);
        st_from = -1;
        st_to = -1;
        lat_chk = 1'b1;

        // Reset with transactions in flight.
        for (int i = 0; i < 4; i++) send8(8'(8'h21 + i), 8'h03, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("rst_pre_valid", out_valid, 1);
        rst = 1'b1;
        #1;
        check("rst_mid_valid", out_valid, 0);
        check("rst_mid_outputs", {sum, cout, ovf}, 0);
        check("rst_mid_ready", in_ready, 1);
        q8.delete();
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        n_out = 0;
        send8(8'h10, 8'h20, 1'b1, 1'b0);
        drain8();
        check("rst_post_count", n_out, 1);

        // Width sweep: W1 and W5 exhaustive, W16 and W64 random, both modes.
        for (int i = 0; i < 10000; i++) begin
            logic [11:0] ev;
            exp_t        e;
            ev = 12'(i);
            @(posedge clk);
            #1;
            s_in_valid = 1'b1;
            s_a[0] = {63'd0, ev[0]};  s_b[0] = {63'd0, ev[1]};
            s_cin[0] = ev[2];         s_sub[0] = ev[3];
            if (i < 4096) begin
                s_a[1] = {59'd0, ev[4:0]}; s_b[1] = {59'd0, ev[9:5]};
                s_cin[1] = ev[10];         s_sub[1] = ev[11];
            end else begin
                s_a[1] = 64'($urandom_range(0, 31)); s_b[1] = 64'($urandom_range(0, 31));
                s_cin[1] = 1'($urandom_range(0, 1)); s_sub[1] = 1'($urandom_range(0, 1));
            end
            s_a[2] = 64'($urandom_range(0, 65535)); s_b[2] = 64'($urandom_range(0, 65535));
            s_cin[2] = 1'($urandom_range(0, 1));     s_sub[2] = 1'($urandom_range(0, 1));
            s_a[3] = {$urandom, $urandom};           s_b[3] = {$urandom, $urandom};
            s_cin[3] = 1'($urandom_range(0, 1));     s_sub[3] = 1'($urandom_range(0, 1));
            if (i == 0) begin
                s_a[3] = 64'hFFFF_FFFF_FFFF_FFFF; s_b[3] = 64'd1; s_cin[3] = 1'b0; s_sub[3] = 1'b0;
            end
            @(negedge clk);
            for (int w = 0; w < 4; w++) begin
                if (s_in_ready[w]) begin
                    e.r = ref_add(sw_w[w], s_a[w], s_b[w], s_cin[w], s_sub[w]);
                    e.c = cyc;
                    sq[w].push_back(e);
                end else begin
                    check($sformatf("sw_in_ready_w%0d", sw_w[w]), s_in_ready[w], 1);
                end
            end
        end
        @(posedge clk);
        #1;
        s_in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        for (int w = 0; w < 4; w++) check($sformatf("sw_drain_w%0d", sw_w[w]), sq[w].size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errors);
        $finish;
    end

endmodule
